// File: rtl/filtro_temp.sv
// Temperature front-end: range and spike rejection, power-of-two moving average,
// and sensor-fault detection after repeated consecutive rejections.
module filtro_temp #(
    parameter int unsigned N_PROM    = 4,
    parameter int          TEMP_MIN  = -400,
    parameter int          TEMP_MAX  = 1000,
    parameter int          SALTO_MAX = 100,
    parameter int unsigned N_FALLAS  = 3
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               muestra_valida,
    input  logic signed [10:0] muestra,
    output logic signed [10:0] temp_filtrada,
    output logic               dato_valido,
    output logic               falla_sensor,
    output logic               listo,
    output logic        [1:0]  cont_fallas,
    output logic        [1:0]  estado
);

    localparam int unsigned LogN = $clog2(N_PROM);
    localparam int unsigned SumW = 11 + LogN;

    localparam logic signed [10:0] TempMin  = 11'(TEMP_MIN);
    localparam logic signed [10:0] TempMax  = 11'(TEMP_MAX);
    localparam logic signed [11:0] SaltoMax = 12'(SALTO_MAX);
    localparam logic        [1:0]  NFallas  = 2'(N_FALLAS);

    typedef enum logic [1:0] {
        StInicio = 2'b00,
        StActivo = 2'b01,
        StFalla  = 2'b10
    } estado_e;

    estado_e                   estado_q, estado_d;
    logic signed [10:0]        ventana_q [N_PROM];
    logic signed [10:0]        ventana_d [N_PROM];
    logic signed [SumW-1:0]    suma_q, suma_d;
    logic        [LogN-1:0]    ptr_q, ptr_d;
    logic signed [10:0]        temp_q, temp_d;
    logic                      valido_q, valido_d;
    logic                      listo_q, listo_d;
    logic        [1:0]         cont_q, cont_d;

    logic                      en_rango;
    logic                      salto;
    logic                      acepta;
    logic                      rechaza;
    logic signed [11:0]        dif;
    logic signed [11:0]        dif_abs;
    logic signed [SumW-1:0]    muestra_ext;
    logic signed [SumW-1:0]    viejo_ext;

    // 12-bit difference cannot overflow for any pair of 11-bit operands.
    always_comb begin
        dif         = {muestra[10], muestra} - {temp_q[10], temp_q};
        dif_abs     = dif[11] ? -dif : dif;
        salto       = dif_abs > SaltoMax;
        en_rango    = (muestra >= TempMin) && (muestra <= TempMax);
        acepta      = muestra_valida && en_rango && !((estado_q == StActivo) && salto);
        rechaza     = muestra_valida && !acepta;
        muestra_ext = {{LogN{muestra[10]}}, muestra};
        viejo_ext   = {{LogN{ventana_q[ptr_q][10]}}, ventana_q[ptr_q]};
    end

    always_comb begin
        estado_d  = estado_q;
        ventana_d = ventana_q;
        suma_d    = suma_q;
        ptr_d     = ptr_q;
        temp_d    = temp_q;
        valido_d  = 1'b0;
        listo_d   = listo_q;
        cont_d    = cont_q;

        if (acepta) begin
            cont_d   = 2'd0;
            listo_d  = 1'b1;
            valido_d = 1'b1;
            estado_d = StActivo;
            if (estado_q == StActivo) begin
                ventana_d[ptr_q] = muestra;
                suma_d           = suma_q + muestra_ext - viejo_ext;
                ptr_d            = ptr_q + LogN'(1);
            end else begin
                // Seeding: every slot holds the sample, so the mean equals it exactly.
                for (int i = 0; i < int'(N_PROM); i++) begin
                    ventana_d[i] = muestra;
                end
                suma_d = muestra_ext <<< LogN;
                ptr_d  = '0;
            end
            // Dropping the low bits of a two's-complement sum floors toward -inf.
            temp_d = suma_d[SumW-1:LogN];
        end else if (rechaza) begin
            if (cont_q < NFallas) begin
                cont_d = cont_q + 2'd1;
            end
            if (cont_d == NFallas) begin
                estado_d = StFalla;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            estado_q <= StInicio;
            for (int i = 0; i < int'(N_PROM); i++) begin
                ventana_q[i] <= '0;
            end
            suma_q   <= '0;
            ptr_q    <= '0;
            temp_q   <= '0;
            valido_q <= 1'b0;
            listo_q  <= 1'b0;
            cont_q   <= 2'd0;
        end else begin
            estado_q  <= estado_d;
            ventana_q <= ventana_d;
            suma_q    <= suma_d;
            ptr_q     <= ptr_d;
            temp_q    <= temp_d;
            valido_q  <= valido_d;
            listo_q   <= listo_d;
            cont_q    <= cont_d;
        end
    end

    assign temp_filtrada = temp_q;
    assign dato_valido   = valido_q;
    assign falla_sensor  = (estado_q == StFalla);
    assign listo         = listo_q;
    assign cont_fallas   = cont_q;
    assign estado        = estado_q;

endmodule

// File: tb/tb_filtro_temp.sv
// Scoreboard bench for filtro_temp: a behavioural model pushes expected outputs
// per driven cycle; they are popped and compared one cycle later.
module tb_filtro_temp;

    localparam int NP = 4;

    logic               clk;
    logic               arst_n;
    logic               muestra_valida;
    logic signed [10:0] muestra;
    logic signed [10:0] temp_filtrada;
    logic               dato_valido;
    logic               falla_sensor;
    logic               listo;
    logic        [1:0]  cont_fallas;
    logic        [1:0]  estado;

    filtro_temp dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .muestra_valida (muestra_valida),
        .muestra        (muestra),
        .temp_filtrada  (temp_filtrada),
        .dato_valido    (dato_valido),
        .falla_sensor   (falla_sensor),
        .listo          (listo),
        .cont_fallas    (cont_fallas),
        .estado         (estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int temp;
        int pulse;
        int falla;
        int listo;
        int cont;
        int est;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    int m_win[NP];
    int m_sum, m_ptr, m_temp, m_pulse, m_listo, m_cont, m_st;

    task automatic check_eq(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int floor_div(input int x, input int d);
        if (x >= 0) return x / d;
        return -((-x + d - 1) / d);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) m_win[i] = 0;
        m_sum = 0; m_ptr = 0; m_temp = 0; m_pulse = 0;
        m_listo = 0; m_cont = 0; m_st = 0;
    endtask

    task automatic model_step(input bit v, input int s);
        bit ok;
        int d;
        m_pulse = 0;
        if (v) begin
            d  = s - m_temp;
            if (d < 0) d = -d;
            ok = (s >= -400) && (s <= 1000) && !((m_st == 1) && (d > 100));
            if (ok) begin
                if (m_st != 1) begin
                    for (int i = 0; i < NP; i++) m_win[i] = s;
                    m_sum = NP * s;
                    m_ptr = 0;
                end else begin
                    m_sum = m_sum + s - m_win[m_ptr];
                    m_win[m_ptr] = s;
                    m_ptr = (m_ptr + 1) % NP;
                end
                m_temp  = floor_div(m_sum, NP);
                m_pulse = 1;
                m_listo = 1;
                m_cont  = 0;
                m_st    = 1;
            end else begin
                if (m_cont < 3) m_cont++;
                if (m_cont == 3) m_st = 2;
            end
        end
    endtask

    task automatic compare_outputs(input exp_t e);
        check_eq("temp_filtrada", int'(temp_filtrada), e.temp);
        check_eq("dato_valido",   int'(dato_valido),   e.pulse);
        check_eq("falla_sensor",  int'(falla_sensor),  e.falla);
        check_eq("listo",         int'(listo),         e.listo);
        check_eq("cont_fallas",   int'(cont_fallas),   e.cont);
        check_eq("estado",        int'(estado),        e.est);
    endtask

    task automatic step(input bit v, input int s);
        exp_t e;
        @(negedge clk);
        muestra_valida = v;
        muestra        = 11'(s);
        model_step(v, s);
        e = '{m_temp, m_pulse, (m_st == 2) ? 1 : 0, m_listo, m_cont, m_st};
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq("scoreboard_empty", 0, 1);
        end else begin
            compare_outputs(sb.pop_front());
        end
    endtask

    task automatic do_reset();
        exp_t z;
        @(negedge clk);
        muestra_valida = 1'b0;
        arst_n         = 1'b0;
        model_reset();
        #2;
        z = '{0, 0, 0, 0, 0, 0};
        compare_outputs(z);
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    initial begin
        exp_t z;
        int   s;
        arst_n         = 1'b0;
        muestra_valida = 1'b0;
        muestra        = '0;
        model_reset();

        // First sample after reset seeds the window
        do_reset();
        step(1, 250);
        check_eq("seed250", int'(temp_filtrada), 250);

        // Averaging ramp
        do_reset();
        step(1, 200);
        step(1, 240);
        check_eq("avg210", int'(temp_filtrada), 210);
        step(1, 240);
        step(1, 240);
        step(1, 240);
        check_eq("avg240", int'(temp_filtrada), 240);

        // Spike rejection then acceptance at 90 away
        do_reset();
        step(1, 210);
        step(1, 400);
        step(0, 0);
        step(1, 300);
        check_eq("avg232", int'(temp_filtrada), 232);

        // Fault entry and recovery
        do_reset();
        step(1, 210);
        step(1, 400);
        step(1, 400);
        step(1, 400);
        check_eq("falla_on", int'(falla_sensor), 1);
        step(1, 1500 - 2048);  // idle-ish: in-range value only if it passes; use out-of-range instead below
        step(1, 400);
        check_eq("recover400", int'(temp_filtrada), 400);

        // Range edges from INICIO
        do_reset();
        step(1, -401);
        step(1, 1001);
        step(1, -400);
        check_eq("edge_min", int'(temp_filtrada), -400);
        do_reset();
        step(1, 1000);
        check_eq("edge_max", int'(temp_filtrada), 1000);

        // Negative flooring
        do_reset();
        step(1, -2);
        step(1, -1);
        check_eq("floor_neg", int'(temp_filtrada), -2);

        // Reset between strobe and its output edge
        do_reset();
        step(1, 300);
        @(negedge clk);
        muestra_valida = 1'b1;
        muestra        = 11'(320);
        #2;
        arst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        z = '{0, 0, 0, 0, 0, 0};
        compare_outputs(z);
        @(negedge clk);
        muestra_valida = 1'b0;
        arst_n         = 1'b1;

        // Back-to-back strobes
        step(1, 0);
        step(1, 4);
        check_eq("b2b_1", int'(temp_filtrada), 1);
        step(1, 8);
        step(1, 12);
        step(1, 16);
        check_eq("b2b_10", int'(temp_filtrada), 10);

        // Random traffic around the running average, with occasional wild samples
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                s = int'($urandom_range(0, 2047)) - 1024;
            end else begin
                s = m_temp + int'($urandom_range(0, 260)) - 130;
                if (s > 1023) s = 1023;
                if (s < -1024) s = -1024;
            end
            step($urandom_range(0, 3) != 0, s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
